bach_rd_return_router: RTL and testbench
========================================

BACH_RD_RETURN_ROUTER -- requirements
Module: bach_rd_return_router

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding read bursts tracked (power of two, 2..16).
REQ-002 SHALL have clock and reset ports Clk and Rstn: one clock; reset is asynchronous and active-low.
REQ-003 Clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Rstn  input  1  asynchronous active-low reset.
REQ-005 issue_valid  input  1  read command accepted by the memory side this cycle (di_AvlRead & ~di_AvlWaitRequest).
REQ-006 issue_agent  input  2  granted agent for the accepted read (0, 1 or 2; 3 is illegal).
REQ-007 issue_burstcount  input  3  burst length of the accepted read.
REQ-008 issue_ready  output  1  tag FIFO can accept an entry; the arbiter SHALL NOT grant reads while it is low.
REQ-009 di_AvlReadData  input  32  memory-side read data.
REQ-010 di_AvlReadDataValid  input  1  memory-side read data valid.
REQ-011 d0_AvlReadData, d1_AvlReadData, d2_AvlReadData  output  32 each  per-agent read data.
REQ-012 d0_AvlReadDataValid, d1_AvlReadDataValid, d2_AvlReadDataValid  output  1 each  per-agent read data valid.
REQ-013 outstanding  output  5  number of tag FIFO entries currently held.
REQ-014 err_unexpected  output  1  single-cycle pulse flagging a protocol error.
REQ-015 err_count  output  8  saturating error count.

Function
REQ-016 SHALL keep a DEPTH-entry in-order tag FIFO, each entry holding {agent[1:0], beats[3:0]}.
REQ-017 Beats SHALL equal issue_burstcount, except burstcount 0 SHALL be stored as 8.
REQ-018 SHALL push when issue_valid & issue_ready & issue_agent != 3.
REQ-019 issue_agent == 3 with issue_valid SHALL push nothing and pulse err_unexpected.
REQ-020 issue_ready SHALL be ~full; a same-cycle pop SHALL NOT raise issue_ready in that cycle.
REQ-021 issue_valid while issue_ready is low SHALL push nothing and pulse err_unexpected.
REQ-022 A beat-remaining counter SHALL load from the head entry's beats and decrement on each di_AvlReadDataValid.
REQ-023 On the final beat the head SHALL pop and the counter SHALL load from the next entry in the following cycle.
REQ-024 Each beat SHALL raise the head agent's dN_AvlReadDataValid exactly one cycle after di_AvlReadDataValid (registered); the other two valids SHALL stay 0.
REQ-025 di_AvlReadData SHALL be registered once and driven identically to all three dN_AvlReadData outputs; data is qualified only by valid.
REQ-026 When no data beat is in flight, dN_AvlReadData SHALL hold its last value.
REQ-027 di_AvlReadDataValid with an empty FIFO SHALL drop the beat, keep all valids low and pulse err_unexpected one cycle later.
REQ-028 A push into an empty FIFO SHALL be visible to data no earlier than the next cycle; data arriving in the push cycle is treated as REQ-027.
REQ-029 Simultaneous push and pop SHALL leave outstanding unchanged.
REQ-030 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-031 outstanding SHALL never exceed DEPTH.

Reset
REQ-032 Rstn low SHALL asynchronously clear the pointers, outstanding, the beat counter, all dN_AvlReadDataValid, err_unexpected and err_count.
REQ-033 On reset, issue_ready SHALL go 1 and all dN_AvlReadData outputs SHALL go 0.
REQ-034 Reset mid-burst SHALL discard all outstanding tags; beats arriving after reset fall under REQ-027.

Configuration
REQ-035 With macro BACH_RDR_ERR_CNT_EN defined, err_count SHALL increment on each err_unexpected pulse and saturate at 255.
REQ-036 Without BACH_RDR_ERR_CNT_EN, err_count SHALL be constant 0 and err_unexpected SHALL behave unchanged.

Verification
REQ-037 The bench SHALL cover: push agent1 bc=4, 4 data beats -> d1 valid for 4 cycles, each 1 cycle delayed; outstanding 1 -> 0 after the last beat; d0 and d2 valids stay 0.
REQ-038 The bench SHALL cover: push agent0 bc=2, then agent2 bc=3, then 5 back-to-back beats -> d0 valid 2 cycles followed by d2 valid 3 cycles with no gap.
REQ-039 The bench SHALL cover: fill 4 tags -> issue_ready=0; issue_valid anyway -> no push, err_unexpected pulse, err_count=1 with the macro and 0 without it.
REQ-040 The bench SHALL cover: data valid with an empty FIFO -> all dN valids 0 and an err_unexpected pulse; push agent3 -> an err_unexpected pulse.
REQ-041 The bench SHALL cover: burstcount 0 push -> exactly 8 beats routed before the pop.
REQ-042 The bench SHALL cover: Rstn low after 1 of 4 beats -> outstanding 0 and issue_ready 1; the remaining 3 beats are dropped with 3 error pulses.

Source files
------------

// File: rtl/bach_rd_return_router.sv
// bach_rd_return_router: routes Avalon read-data beats back to the agent
// that issued each read burst, using an in-order tag FIFO of {agent, beats}.
//
// Ports
//   Clk, Rstn               clock, asynchronous active-low reset
//   issue_valid/agent/burstcount  accepted read command from the arbiter
//   issue_ready             tag FIFO has room (registered, ~full)
//   di_AvlReadData/Valid    memory-side read return
//   dN_AvlReadData/Valid    per-agent read return (N = 0..2), one cycle later
//   outstanding             tag entries currently held
//   err_unexpected          one-cycle pulse on a protocol error
//   err_count               saturating error count
//
// Optional feature: define BACH_RDR_ERR_CNT_EN to enable err_count;
// otherwise err_count is tied to 0.

module bach_rd_return_router #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        issue_valid,
  input  logic [1:0]  issue_agent,
  input  logic [2:0]  issue_burstcount,
  output logic        issue_ready,
  input  logic [31:0] di_AvlReadData,
  input  logic        di_AvlReadDataValid,
  output logic [31:0] d0_AvlReadData,
  output logic [31:0] d1_AvlReadData,
  output logic [31:0] d2_AvlReadData,
  output logic        d0_AvlReadDataValid,
  output logic        d1_AvlReadDataValid,
  output logic        d2_AvlReadDataValid,
  output logic [4:0]  outstanding,
  output logic        err_unexpected,
  output logic [7:0]  err_count
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  // Tag storage (no reset needed: only read while count != 0)
  logic [1:0] tag_agent [DEPTH];
  logic [3:0] tag_beats [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]       count;
  logic [3:0]       beat_cnt;
  logic             cnt_vld;
  logic             ready_q;
  logic [31:0]      data_q;
  logic [2:0]       dv_q;
  logic             err_q;

  logic       push_c, head_vld_c, beat_c, pop_c, err_c;
  logic [3:0] remaining_c, in_beats_c;
  logic [4:0] count_nxt_c;

  // Next-state decode. count is registered, so an entry pushed this cycle
  // is not seen by the data side until the following cycle.
  always_comb begin
    push_c      = 1'b0;
    head_vld_c  = 1'b0;
    beat_c      = 1'b0;
    remaining_c = 4'd0;
    pop_c       = 1'b0;
    err_c       = 1'b0;
    in_beats_c  = 4'd0;
    count_nxt_c = count;

    push_c      = issue_valid & ready_q & (issue_agent != 2'd3);
    head_vld_c  = (count != 5'd0);
    beat_c      = di_AvlReadDataValid & head_vld_c;
    // Until the first beat of a burst, the count comes straight from the head
    remaining_c = cnt_vld ? beat_cnt : tag_beats[rd_ptr];
    pop_c       = beat_c & (remaining_c == 4'd1);
    err_c       = (issue_valid & (~ready_q | (issue_agent == 2'd3)))
                | (di_AvlReadDataValid & ~head_vld_c);
    in_beats_c  = (issue_burstcount == 3'd0) ? 4'd8 : {1'b0, issue_burstcount};
    count_nxt_c = count + 5'(push_c) - 5'(pop_c);
  end

  // Tag FIFO write port
  always_ff @(posedge Clk) begin
    if (push_c) begin
      tag_agent[wr_ptr] <= issue_agent;
      tag_beats[wr_ptr] <= in_beats_c;
    end
  end

  // Pointers, occupancy, beat counter and registered outputs
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      beat_cnt <= 4'd0;
      cnt_vld  <= 1'b0;
      ready_q  <= 1'b1;
      data_q   <= 32'd0;
      dv_q     <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      count   <= count_nxt_c;
      ready_q <= (count_nxt_c != DEPTH_C);
      err_q   <= err_c;
      dv_q    <= 3'd0;
      if (beat_c) begin
        data_q <= di_AvlReadData;
        dv_q   <= 3'b001 << tag_agent[rd_ptr];
        if (pop_c) begin
          rd_ptr   <= rd_ptr + PTR_W'(1);
          beat_cnt <= 4'd0;
          cnt_vld  <= 1'b0;
        end else begin
          beat_cnt <= remaining_c - 4'd1;
          cnt_vld  <= 1'b1;
        end
      end
    end
  end

`ifdef BACH_RDR_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating error counter
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      err_cnt_q <= 8'd0;
    end else if (err_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign issue_ready         = ready_q;
  assign outstanding         = count;
  assign err_unexpected      = err_q;
  assign d0_AvlReadData      = data_q;
  assign d1_AvlReadData      = data_q;
  assign d2_AvlReadData      = data_q;
  assign d0_AvlReadDataValid = dv_q[0];
  assign d1_AvlReadDataValid = dv_q[1];
  assign d2_AvlReadDataValid = dv_q[2];

endmodule

// File: tb/tb_bach_rd_return_router.sv
// Scoreboard bench for bach_rd_return_router: directed stimulus pushes the
// expected routed beat / error pulse (with its cycle stamp) into queues; a
// negedge monitor pops and compares whatever the DUT presents.

module tb_bach_rd_return_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_agent = 2'd0;
  logic [2:0]  issue_burstcount = 3'd0;
  logic        issue_ready;
  logic [31:0] di_data = 32'd0;
  logic        di_valid = 1'b0;
  logic [31:0] d0_data, d1_data, d2_data;
  logic        d0_valid, d1_valid, d2_valid;
  logic [4:0]  outstanding;
  logic        err_unexpected;
  logic [7:0]  err_count;

  bach_rd_return_router #(.DEPTH(4)) dut (
    .Clk                 (clk),
    .Rstn                (rst_n),
    .issue_valid         (issue_valid),
    .issue_agent         (issue_agent),
    .issue_burstcount    (issue_burstcount),
    .issue_ready         (issue_ready),
    .di_AvlReadData      (di_data),
    .di_AvlReadDataValid (di_valid),
    .d0_AvlReadData      (d0_data),
    .d1_AvlReadData      (d1_data),
    .d2_AvlReadData      (d2_data),
    .d0_AvlReadDataValid (d0_valid),
    .d1_AvlReadDataValid (d1_valid),
    .d2_AvlReadDataValid (d2_valid),
    .outstanding         (outstanding),
    .err_unexpected      (err_unexpected),
    .err_count           (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  agent;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs once per negedge
  task automatic mon_step();
    exp_t e;
    int   nv;
    int   ec;
    logic [1:0] ag;
    if (!rst_n) return;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_beat_cycle", 32'(cyc), 32'(e.cyc));
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      ec = err_q.pop_front();
      chk("missing_err_cycle", 32'(cyc), 32'(ec));
    end
    nv = int'(d0_valid) + int'(d1_valid) + int'(d2_valid);
    if (nv > 1) chk("onehot_valids", 32'(nv), 32'd1);
    if (nv == 1) begin
      ag = d0_valid ? 2'd0 : (d1_valid ? 2'd1 : 2'd2);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_agent", 32'(ag), 32'hFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_cycle", 32'(cyc), 32'(e.cyc));
        chk("beat_agent", 32'(ag), 32'(e.agent));
        chk("d0_data", d0_data, e.data);
        chk("d1_data", d1_data, e.data);
        chk("d2_data", d2_data, e.data);
      end
    end
    if (err_unexpected) begin
      if (err_q.size() == 0) begin
        chk("unexpected_err_pulse", 32'd1, 32'd0);
      end else begin
        ec = err_q.pop_front();
        chk("err_cycle", 32'(cyc), 32'(ec));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] agent, input logic [2:0] bc);
    issue_valid = 1'b1; issue_agent = agent; issue_burstcount = bc;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic push_err(input logic [1:0] agent, input logic [2:0] bc);
    err_q.push_back(cyc + 1);
    model_errs++;
    push(agent, bc);
  endtask

  task automatic beat(input logic [1:0] agent, input logic [31:0] data);
    exp_t e;
    e.cyc = cyc + 1; e.agent = agent; e.data = data;
    exp_q.push_back(e);
    di_valid = 1'b1; di_data = data;
    tick();
    di_valid = 1'b0;
  endtask

  task automatic beat_drop(input logic [31:0] data);
    err_q.push_back(cyc + 1);
    model_errs++;
    di_valid = 1'b1; di_data = data;
    tick();
    di_valid = 1'b0;
  endtask

  task automatic chk_err_count();
`ifdef BACH_RDR_ERR_CNT_EN
    chk("err_count", 32'(err_count), (model_errs > 255) ? 32'd255 : 32'(model_errs));
`else
    chk("err_count", 32'(err_count), 32'd0);
`endif
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset state
    #12;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_valids", 32'({d0_valid, d1_valid, d2_valid}), 32'd0);
    chk("rst_d0_data", d0_data, 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Agent1, burst 4
    push(2'd1, 3'd4);
    chk("a_outstanding_1", 32'(outstanding), 32'd1);
    beat(2'd1, 32'h1111_0001);
    beat(2'd1, 32'h1111_0002);
    beat(2'd1, 32'h1111_0003);
    chk("a_outstanding_mid", 32'(outstanding), 32'd1);
    beat(2'd1, 32'h1111_0004);
    chk("a_outstanding_0", 32'(outstanding), 32'd0);
    repeat (2) tick();

    // Agent0 bc2 then agent2 bc3, 5 back-to-back beats
    push(2'd0, 3'd2);
    push(2'd2, 3'd3);
    chk("b_outstanding_2", 32'(outstanding), 32'd2);
    beat(2'd0, 32'hB000_0000);
    beat(2'd0, 32'hB000_0001);
    beat(2'd2, 32'hB000_0002);
    beat(2'd2, 32'hB000_0003);
    beat(2'd2, 32'hB000_0004);
    chk("b_outstanding_0", 32'(outstanding), 32'd0);
    repeat (2) tick();

    // Fill, then issue while not ready
    push(2'd0, 3'd1);
    push(2'd1, 3'd1);
    push(2'd2, 3'd1);
    chk("c_ready_3", 32'(issue_ready), 32'd1);
    push(2'd0, 3'd1);
    chk("c_ready_full", 32'(issue_ready), 32'd0);
    chk("c_outstanding_4", 32'(outstanding), 32'd4);
    push_err(2'd1, 3'd2);
    chk("c_no_push", 32'(outstanding), 32'd4);
    chk_err_count();
    beat(2'd0, 32'hC000_0000);
    beat(2'd1, 32'hC000_0001);
    beat(2'd2, 32'hC000_0002);
    beat(2'd0, 32'hC000_0003);
    chk("c_ready_drained", 32'(issue_ready), 32'd1);
    chk("c_outstanding_0", 32'(outstanding), 32'd0);
    repeat (2) tick();

    // Simultaneous push and pop
    push(2'd1, 3'd1);
    issue_valid = 1'b1; issue_agent = 2'd2; issue_burstcount = 3'd1;
    beat(2'd1, 32'hD000_0000);
    issue_valid = 1'b0;
    chk("d_outstanding_same", 32'(outstanding), 32'd1);
    beat(2'd2, 32'hD000_0001);
    chk("d_outstanding_0", 32'(outstanding), 32'd0);
    repeat (2) tick();

    // Data with empty FIFO, agent3 push, push+data in same cycle
    beat_drop(32'hE000_0000);
    push_err(2'd3, 3'd1);
    chk("e_agent3_no_push", 32'(outstanding), 32'd0);
    issue_valid = 1'b1; issue_agent = 2'd0; issue_burstcount = 3'd1;
    beat_drop(32'hE000_0001);
    issue_valid = 1'b0;
    chk("e_push_seen", 32'(outstanding), 32'd1);
    beat(2'd0, 32'hE000_0002);
    chk("e_outstanding_0", 32'(outstanding), 32'd0);
    tick();
    chk_err_count();

    // Burstcount 0 means 8 beats
    push(2'd2, 3'd0);
    for (int i = 0; i < 7; i++) beat(2'd2, 32'hF000_0000 + 32'(i));
    chk("f_outstanding_7", 32'(outstanding), 32'd1);
    beat(2'd2, 32'hF000_0007);
    chk("f_outstanding_8", 32'(outstanding), 32'd0);
    beat_drop(32'hF000_0008);
    repeat (2) tick();
    chk_err_count();

    // Reset mid-burst
    push(2'd1, 3'd4);
    beat(2'd1, 32'h6000_0000);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_errs = 0;
    chk("g_rst_outstanding", 32'(outstanding), 32'd0);
    chk("g_rst_ready", 32'(issue_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    beat_drop(32'h6000_0001);
    beat_drop(32'h6000_0002);
    beat_drop(32'h6000_0003);
    repeat (2) tick();
    chk("g_outstanding", 32'(outstanding), 32'd0);
    chk_err_count();

    repeat (3) tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("err_q_empty", 32'(err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
